// File: rtl/instr_sequencer.sv
// Q-cycle sequencer and instruction decoder for the PIC16-style core.
// Steps each instruction through Q_CYCLES phases. The second-to-last phase
// (EXEC) drives ALU/register-file controls, the last phase (COMMIT) drives
// PC, stack and instruction-register controls. Also tracks return-stack
// depth, pending interrupts and flags undecodable opcodes.
module instr_sequencer #(
  parameter int Q_CYCLES    = 4,
  parameter int INSTR_W     = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INSTR_W-1:0]               instr_current,
  input  logic                             stall,
  input  logic                             irq_req,
  input  logic                             gie,
  input  logic                             bit_test_res,
  input  logic                             status_z,
  output logic [$clog2(Q_CYCLES)-1:0]      q_count,
  output logic [3:0]                       alu_op,
  output logic                             alu_sel_l,
  output logic                             alu_status_wr_en,
  output logic                             f_wr_en,
  output logic                             w_wr_en,
  output logic                             instr_rd_en,
  output logic                             instr_flush,
  output logic                             pc_incr_en,
  output logic                             pc_j_en,
  output logic                             pc_j_and_push_en,
  output logic                             pc_j_by_pop_en,
  output logic                             pc_irq_vec_sel,
  output logic                             irq_ack,
  output logic                             gie_clr,
  output logic                             gie_set,
  output logic                             illegal_op,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_ovf,
  output logic                             stack_unf
);
  localparam int QW = $clog2(Q_CYCLES);
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam logic [QW-1:0] Q_EXEC   = QW'(Q_CYCLES-2);
  localparam logic [QW-1:0] Q_COMMIT = QW'(Q_CYCLES-1);
  localparam logic [DW-1:0] D_MAX    = DW'(STACK_DEPTH);

  // ALU operation codes; BIT covers bcf/bsf/btfsc/btfss (ALU reads instr[11:10])
  localparam logic [3:0] ALU_NOP = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_AND = 4'd3;
  localparam logic [3:0] ALU_IOR = 4'd4,  ALU_XOR = 4'd5,  ALU_COM = 4'd6,  ALU_INC = 4'd7;
  localparam logic [3:0] ALU_DEC = 4'd8,  ALU_RRF = 4'd9,  ALU_RLF = 4'd10, ALU_SWAP = 4'd11;
  localparam logic [3:0] ALU_PASSLF = 4'd12, ALU_PASSW = 4'd13, ALU_CLR = 4'd14, ALU_BIT = 4'd15;

  typedef enum logic [2:0] {CK_NORMAL, CK_SKIP, CK_GOTO, CK_CALL, CK_RET, CK_RETFIE} commit_kind_t;

  logic [13:0]  op;
  logic [3:0]   d_op;
  logic         d_sel, d_st, d_f, d_w, d_skip_cond, d_illegal;
  commit_kind_t d_kind;
  logic         irq_pend;
  logic         exec_ph, commit_ph;

  assign op        = instr_current[13:0];
  assign exec_ph   = !rst && !stall && (q_count == Q_EXEC);
  assign commit_ph = !rst && !stall && (q_count == Q_COMMIT);

  // Phase counter: wraps after COMMIT, frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     q_count <= '0;
    else if (!stall) q_count <= (q_count == Q_COMMIT) ? '0 : q_count + QW'(1);
  end

  // Opcode decode into EXEC controls and commit class
  always_comb begin
    d_op = ALU_NOP; d_sel = 1'b0; d_st = 1'b0; d_f = 1'b0; d_w = 1'b0;
    d_skip_cond = 1'b0; d_illegal = 1'b0; d_kind = CK_NORMAL;
    unique case (op[13:12])
      2'b00: begin
        d_f = op[7];
        d_w = ~op[7];
        case (op[11:8])
          4'h0: if (op[7]) d_op = ALU_PASSW;
                else begin
                  d_f = 1'b0; d_w = 1'b0;
                  case (op[6:0])
                    7'h08: d_kind = CK_RET;
                    7'h09: d_kind = CK_RETFIE;
                    7'h00, 7'h20, 7'h40, 7'h60, 7'h63, 7'h64: ; // nop, sleep, clrwdt
                    default: d_illegal = 1'b1;
                  endcase
                end
          4'h1: begin d_op = ALU_CLR;    d_st = 1'b1; end
          4'h2: begin d_op = ALU_SUB;    d_st = 1'b1; end
          4'h3: begin d_op = ALU_DEC;    d_st = 1'b1; end
          4'h4: begin d_op = ALU_IOR;    d_st = 1'b1; end
          4'h5: begin d_op = ALU_AND;    d_st = 1'b1; end
          4'h6: begin d_op = ALU_XOR;    d_st = 1'b1; end
          4'h7: begin d_op = ALU_ADD;    d_st = 1'b1; end
          4'h8: begin d_op = ALU_PASSLF; d_st = 1'b1; end
          4'h9: begin d_op = ALU_COM;    d_st = 1'b1; end
          4'hA: begin d_op = ALU_INC;    d_st = 1'b1; end
          4'hB: begin d_op = ALU_DEC;    d_st = 1'b1; d_kind = CK_SKIP; d_skip_cond = status_z; end
          4'hC: begin d_op = ALU_RRF;    d_st = 1'b1; end
          4'hD: begin d_op = ALU_RLF;    d_st = 1'b1; end
          4'hE: d_op = ALU_SWAP;
          default: begin d_op = ALU_INC; d_st = 1'b1; d_kind = CK_SKIP; d_skip_cond = status_z; end
        endcase
      end
      2'b01: begin
        d_op = ALU_BIT;
        if (!op[11]) d_f = 1'b1;
        else begin d_kind = CK_SKIP; d_skip_cond = bit_test_res; end
      end
      2'b10: d_kind = op[11] ? CK_GOTO : CK_CALL;
      default: begin
        d_sel = 1'b1;
        d_w   = 1'b1;
        case (op[11:8])
          4'h0, 4'h1, 4'h2, 4'h3: d_op = ALU_PASSLF;
          4'h4, 4'h5, 4'h6, 4'h7: begin d_op = ALU_PASSLF; d_kind = CK_RET; end
          4'h8: begin d_op = ALU_IOR; d_st = 1'b1; end
          4'h9: begin d_op = ALU_AND; d_st = 1'b1; end
          4'hA: begin d_op = ALU_XOR; d_st = 1'b1; end
          4'hB: begin d_sel = 1'b0; d_w = 1'b0; d_illegal = 1'b1; end
          4'hC, 4'hD: begin d_op = ALU_SUB; d_st = 1'b1; end
          default:    begin d_op = ALU_ADD; d_st = 1'b1; end
        endcase
      end
    endcase
  end

  // Phase-gated strobes; an interrupt replaces a normal commit
  always_comb begin
    alu_op = ALU_NOP; alu_sel_l = 1'b0; alu_status_wr_en = 1'b0; f_wr_en = 1'b0; w_wr_en = 1'b0;
    instr_rd_en = 1'b0; instr_flush = 1'b0; pc_incr_en = 1'b0; pc_j_en = 1'b0;
    pc_j_and_push_en = 1'b0; pc_j_by_pop_en = 1'b0; pc_irq_vec_sel = 1'b0;
    irq_ack = 1'b0; gie_clr = 1'b0; gie_set = 1'b0; illegal_op = 1'b0;
    if (exec_ph) begin
      alu_op = d_op; alu_sel_l = d_sel; alu_status_wr_en = d_st; f_wr_en = d_f; w_wr_en = d_w;
    end
    if (commit_ph) begin
      illegal_op = d_illegal;
      case (d_kind)
        CK_NORMAL:
          if (irq_pend) begin
            pc_j_and_push_en = 1'b1; pc_irq_vec_sel = 1'b1; instr_flush = 1'b1;
            gie_clr = 1'b1; irq_ack = 1'b1;
          end else begin
            instr_rd_en = 1'b1; pc_incr_en = 1'b1;
          end
        CK_SKIP: begin
          pc_incr_en = 1'b1;
          if (d_skip_cond) instr_flush = 1'b1;
          else             instr_rd_en = 1'b1;
        end
        CK_GOTO: begin pc_j_en = 1'b1; instr_flush = 1'b1; end
        CK_CALL: begin pc_j_and_push_en = 1'b1; instr_flush = 1'b1; end
        CK_RET:  begin pc_j_by_pop_en = 1'b1; instr_flush = 1'b1; end
        default: begin pc_j_by_pop_en = 1'b1; instr_flush = 1'b1; gie_set = 1'b1; end
      endcase
    end
  end

  // Interrupt pending latch and saturating stack-depth tracker with sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend    <= 1'b0;
      stack_depth <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      if (irq_ack)             irq_pend <= 1'b0;
      else if (irq_req && gie) irq_pend <= 1'b1;
      if (pc_j_and_push_en) begin
        if (stack_depth == D_MAX) stack_ovf   <= 1'b1;
        else                      stack_depth <= stack_depth + DW'(1);
      end
      if (pc_j_by_pop_en) begin
        if (stack_depth == '0) stack_unf   <= 1'b1;
        else                   stack_depth <= stack_depth - DW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a Q=4/depth-2 instance for decode,
// interrupt, stack and reset sequences, and a Q=6 instance for stall.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [13:0] instr;
  logic stall_a, stall_b, irq_req, gie, btr, sz;

  logic [1:0] a_q;  logic [3:0] a_op; logic [1:0] a_depth;
  logic a_sel, a_st, a_fw, a_ww, a_rd, a_fl, a_inc, a_j, a_push, a_pop, a_vec, a_ack, a_gclr, a_gset, a_ill, a_ovf, a_unf;
  logic [2:0] b_q;  logic [3:0] b_op; logic [3:0] b_depth;
  logic b_sel, b_st, b_fw, b_ww, b_rd, b_fl, b_inc, b_j, b_push, b_pop, b_vec, b_ack, b_gclr, b_gset, b_ill, b_ovf, b_unf;

  wire [18:0] sa = {a_op, a_sel, a_st, a_fw, a_ww, a_rd, a_fl, a_inc, a_j, a_push, a_pop, a_vec, a_ack, a_gclr, a_gset, a_ill};
  wire [18:0] sb = {b_op, b_sel, b_st, b_fw, b_ww, b_rd, b_fl, b_inc, b_j, b_push, b_pop, b_vec, b_ack, b_gclr, b_gset, b_ill};

  localparam logic [18:0] SEL = 19'h1 << 14, ST = 19'h1 << 13, FW = 19'h1 << 12, WW = 19'h1 << 11;
  localparam logic [18:0] RD = 19'h1 << 10, FL = 19'h1 << 9, INC = 19'h1 << 8, J = 19'h1 << 7;
  localparam logic [18:0] PUSH = 19'h1 << 6, POP = 19'h1 << 5, VEC = 19'h1 << 4, ACK = 19'h1 << 3;
  localparam logic [18:0] GCLR = 19'h1 << 2, GSET = 19'h1 << 1, ILL = 19'h1;
  localparam logic [18:0] NORM = RD | INC;
  localparam logic [18:0] IRQC = PUSH | VEC | FL | GCLR | ACK;

  function automatic logic [18:0] aop(input int n);
    return 19'(n) << 15;
  endfunction

  instr_sequencer #(.Q_CYCLES(4), .INSTR_W(14), .STACK_DEPTH(2)) ua (
    .clk(clk), .rst(rst), .instr_current(instr), .stall(stall_a), .irq_req(irq_req), .gie(gie),
    .bit_test_res(btr), .status_z(sz), .q_count(a_q), .alu_op(a_op), .alu_sel_l(a_sel),
    .alu_status_wr_en(a_st), .f_wr_en(a_fw), .w_wr_en(a_ww), .instr_rd_en(a_rd), .instr_flush(a_fl),
    .pc_incr_en(a_inc), .pc_j_en(a_j), .pc_j_and_push_en(a_push), .pc_j_by_pop_en(a_pop),
    .pc_irq_vec_sel(a_vec), .irq_ack(a_ack), .gie_clr(a_gclr), .gie_set(a_gset), .illegal_op(a_ill),
    .stack_depth(a_depth), .stack_ovf(a_ovf), .stack_unf(a_unf));

  instr_sequencer #(.Q_CYCLES(6), .INSTR_W(14), .STACK_DEPTH(8)) ub (
    .clk(clk), .rst(rst), .instr_current(instr), .stall(stall_b), .irq_req(irq_req), .gie(gie),
    .bit_test_res(btr), .status_z(sz), .q_count(b_q), .alu_op(b_op), .alu_sel_l(b_sel),
    .alu_status_wr_en(b_st), .f_wr_en(b_fw), .w_wr_en(b_ww), .instr_rd_en(b_rd), .instr_flush(b_fl),
    .pc_incr_en(b_inc), .pc_j_en(b_j), .pc_j_and_push_en(b_push), .pc_j_by_pop_en(b_pop),
    .pc_irq_vec_sel(b_vec), .irq_ack(b_ack), .gie_clr(b_gclr), .gie_set(b_gset), .illegal_op(b_ill),
    .stack_depth(b_depth), .stack_ovf(b_ovf), .stack_unf(b_unf));

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] ins;
    logic        b;
    logic        z;
    logic [18:0] ex;
    logic [18:0] cm;
  } vec_t;
  vec_t tbl[25];

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one Q=4 phase: sample at negedge, then advance
  task automatic phase_chk(input int p, input logic [18:0] exp, input string nm);
    @(negedge clk);
    chk($sformatf("%s q%0d phase", nm, p), a_q, p);
    chk($sformatf("%s q%0d strobes", nm, p), sa, exp);
    tick();
  endtask

  task automatic run_a(input logic [13:0] ins, input logic b, input logic z,
                       input logic [18:0] ex, input logic [18:0] cm, input string nm);
    instr = ins; btr = b; sz = z;
    phase_chk(0, '0, nm);
    phase_chk(1, '0, nm);
    phase_chk(2, ex, nm);
    phase_chk(3, cm, nm);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_b = 1'b0; irq_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 14'h0785; stall_a = 1'b0; stall_b = 1'b0;
    irq_req = 1'b0; gie = 1'b0; btr = 1'b0; sz = 1'b0;

    tbl[0]  = '{14'h0785, 1'b0, 1'b0, aop(1)  | ST | FW,       NORM};      // addwf f
    tbl[1]  = '{14'h0705, 1'b0, 1'b0, aop(1)  | ST | WW,       NORM};      // addwf w
    tbl[2]  = '{14'h0085, 1'b0, 1'b0, aop(13) | FW,            NORM};      // movwf
    tbl[3]  = '{14'h0E85, 1'b0, 1'b0, aop(11) | FW,            NORM};      // swapf
    tbl[4]  = '{14'h0805, 1'b0, 1'b0, aop(12) | ST | WW,       NORM};      // movf w
    tbl[5]  = '{14'h0185, 1'b0, 1'b0, aop(14) | ST | FW,       NORM};      // clrf
    tbl[6]  = '{14'h1485, 1'b0, 1'b0, aop(15) | FW,            NORM};      // bsf
    tbl[7]  = '{14'h1885, 1'b1, 1'b0, aop(15),                 FL | INC};  // btfsc skip
    tbl[8]  = '{14'h1885, 1'b0, 1'b0, aop(15),                 RD | INC};  // btfsc no skip
    tbl[9]  = '{14'h0B85, 1'b0, 1'b1, aop(8)  | ST | FW,       FL | INC};  // decfsz skip
    tbl[10] = '{14'h0B05, 1'b0, 1'b0, aop(8)  | ST | WW,       RD | INC};  // decfsz no skip
    tbl[11] = '{14'h3055, 1'b0, 1'b0, aop(12) | SEL | WW,      NORM};      // movlw
    tbl[12] = '{14'h3E01, 1'b0, 1'b0, aop(1)  | SEL | ST | WW, NORM};      // addlw
    tbl[13] = '{14'h3C01, 1'b0, 1'b0, aop(2)  | SEL | ST | WW, NORM};      // sublw
    tbl[14] = '{14'h2805, 1'b0, 1'b0, '0,                      J | FL};    // goto
    tbl[15] = '{14'h0000, 1'b0, 1'b0, '0,                      NORM};      // nop
    tbl[16] = '{14'h0063, 1'b0, 1'b0, '0,                      NORM};      // sleep
    tbl[17] = '{14'h3B00, 1'b0, 1'b0, '0,                      NORM | ILL};
    tbl[18] = '{14'h0001, 1'b0, 1'b0, '0,                      NORM | ILL};
    tbl[19] = '{14'h2005, 1'b0, 1'b0, '0,                      PUSH | FL}; // call
    tbl[20] = '{14'h3401, 1'b0, 1'b0, aop(12) | SEL | WW,      POP | FL};  // retlw
    tbl[21] = '{14'h2005, 1'b0, 1'b0, '0,                      PUSH | FL};
    tbl[22] = '{14'h0009, 1'b0, 1'b0, '0,                      POP | FL | GSET}; // retfie
    tbl[23] = '{14'h2005, 1'b0, 1'b0, '0,                      PUSH | FL};
    tbl[24] = '{14'h0008, 1'b0, 1'b0, '0,                      POP | FL};  // return

    // reset state
    @(negedge clk);
    chk("reset q", a_q, 0);
    chk("reset strobes", sa, 0);
    chk("reset depth", a_depth, 0);
    chk("reset flags", {a_ovf, a_unf}, 0);
    chk("reset b q", b_q, 0);
    tick();
    rst = 1'b0;

    // decode table
    for (int i = 0; i < 25; i++)
      run_a(tbl[i].ins, tbl[i].b, tbl[i].z, tbl[i].ex, tbl[i].cm, $sformatf("vec%0d", i));
    chk("table depth", a_depth, 0);
    chk("table flags", {a_ovf, a_unf}, 0);

    // interrupt during movlw, taken at its commit
    do_reset();
    gie = 1'b1; instr = 14'h3055; irq_req = 1'b1;
    phase_chk(0, '0, "irq movlw");
    irq_req = 1'b0;
    phase_chk(1, '0, "irq movlw");
    phase_chk(2, aop(12) | SEL | WW, "irq movlw");
    phase_chk(3, IRQC, "irq movlw");
    chk("irq depth", a_depth, 1);
    run_a(14'h0000, 1'b0, 1'b0, '0, NORM, "irq cleared");

    // interrupt arriving during goto waits for the next normal commit
    instr = 14'h2805; irq_req = 1'b1;
    phase_chk(0, '0, "irq goto");
    irq_req = 1'b0;
    phase_chk(1, '0, "irq goto");
    phase_chk(2, '0, "irq goto");
    phase_chk(3, J | FL, "irq goto");
    chk("irq goto depth", a_depth, 1);
    run_a(14'h0000, 1'b0, 1'b0, '0, IRQC, "irq deferred");
    chk("irq deferred depth", a_depth, 2);
    chk("irq deferred ovf", a_ovf, 0);

    // request while gie=0 is never latched
    gie = 1'b0; irq_req = 1'b1;
    run_a(14'h0000, 1'b0, 1'b0, '0, NORM, "irq masked");
    irq_req = 1'b0; gie = 1'b1;
    run_a(14'h0000, 1'b0, 1'b0, '0, NORM, "irq not latched");
    gie = 1'b0;

    // stack saturation: three calls then three returns into depth 2
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_a(14'h2005, 1'b0, 1'b0, '0, PUSH | FL, $sformatf("call%0d", k));
      chk($sformatf("call%0d depth", k), a_depth, (k == 0) ? 1 : 2);
      chk($sformatf("call%0d ovf", k), a_ovf, (k == 2) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      run_a(14'h0008, 1'b0, 1'b0, '0, POP | FL, $sformatf("ret%0d", k));
      chk($sformatf("ret%0d depth", k), a_depth, (k == 0) ? 1 : 0);
      chk($sformatf("ret%0d unf", k), a_unf, (k == 2) ? 1 : 0);
    end
    chk("ovf sticky", a_ovf, 1);

    // reset asserted during a call's commit phase
    do_reset();
    run_a(14'h2005, 1'b0, 1'b0, '0, PUSH | FL, "pre call");
    phase_chk(0, '0, "mid rst");
    phase_chk(1, '0, "mid rst");
    phase_chk(2, '0, "mid rst");
    @(negedge clk);
    chk("mid rst commit", sa, PUSH | FL);
    rst = 1'b1;
    #1;
    chk("mid rst strobes", sa, 0);
    chk("mid rst q", a_q, 0);
    chk("mid rst depth", a_depth, 0);
    tick();
    rst = 1'b0;
    run_a(14'h2005, 1'b0, 1'b0, '0, PUSH | FL, "post rst call");
    chk("post rst depth", a_depth, 1);
    chk("post rst flags", {a_ovf, a_unf}, 0);

    // Q=6 stall at EXEC phase
    do_reset();
    instr = 14'h0785;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk($sformatf("q6 q%0d", p), b_q, p);
      chk($sformatf("q6 q%0d strobes", p), sb, 0);
      tick();
    end
    stall_b = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("q6 stall%0d q", s), b_q, 4);
      chk($sformatf("q6 stall%0d strobes", s), sb, 0);
      tick();
    end
    stall_b = 1'b0;
    @(negedge clk);
    chk("q6 exec q", b_q, 4);
    chk("q6 exec strobes", sb, aop(1) | ST | FW);
    tick();
    @(negedge clk);
    chk("q6 commit q", b_q, 5);
    chk("q6 commit strobes", sb, NORM);
    tick();
    @(negedge clk);
    chk("q6 wrap q", b_q, 0);
    chk("q6 wrap strobes", sb, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
